// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   16-bit instruction fetch address register, downstream of the branch unit.
//   Handles the reset-vector load, absolute jumps (the low byte is latched
//   first, then the high byte arrives with the branch strobe) and signed
//   8-bit relative branches. A relative branch that leaves the current
//   256-byte page takes one extra FIXUP cycle to correct the high byte.
//
// Ports
//   clk_2        in   1   clock, all state updates on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   data_in      in   8   data bus: vector / operand byte for this cycle
//   lower_byte   in   1   latch data_in into the low-address buffer (adl)
//   branch       in   1   load pc (absolute {data_in, adl} or relative)
//   branch_rel   in   1   relative mode, data_in is a signed offset
//   pc_increment in   1   pc <= pc + 1
//   normal       in   1   0 while the branch unit runs its reset sequence
//   pc_hold      in   1   stall: freeze pc, adl and state this cycle
//   pc           out  16  current fetch address (registered)
//   busy         out  1   high during the FIXUP cycle
//   page_cross   out  1   one-cycle pulse in the cycle FIXUP is entered
// ---------------------------------------------------------------------------
module program_counter #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        clk_2,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        lower_byte,
    input  logic        branch,
    input  logic        branch_rel,
    input  logic        pc_increment,
    input  logic        normal,
    input  logic        pc_hold,
    output logic [15:0] pc,
    output logic        busy,
    output logic        page_cross
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FIXUP = 1'b1;

    logic [0:0] state;
    logic [7:0] adl;
    logic       dir_fwd;

    logic       rel_mode;
    logic [8:0] sum9;
    logic       crossing;

    // During the reset sequence the branch is always an absolute vector load.
    assign rel_mode = branch_rel & normal;

    // Unsigned add of the offset to the low byte; the carry out, read
    // against the offset sign, tells whether the target left the page.
    assign sum9     = {1'b0, pc[7:0]} + {1'b0, data_in};
    assign crossing = data_in[7] ? ~sum9[8] : sum9[8];

    assign busy = (state == FIXUP);

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            adl        <= 8'h00;
            state      <= RUN;
            page_cross <= 1'b0;
            dir_fwd    <= 1'b0;
        end else if (pc_hold) begin
            page_cross <= 1'b0;
        end else begin
            page_cross <= 1'b0;
            case (state)
                RUN: begin
                    if (lower_byte) begin
                        adl <= data_in;
                    end
                    // branch has priority; a simultaneous increment is dropped
                    if (branch) begin
                        if (rel_mode) begin
                            pc[7:0] <= sum9[7:0];
                            if (crossing) begin
                                state      <= FIXUP;
                                page_cross <= 1'b1;
                                dir_fwd    <= ~data_in[7];
                            end
                        end else begin
                            // adl is the value from before this edge
                            pc <= {data_in, adl};
                        end
                    end else if (pc_increment) begin
                        pc <= pc + 16'd1;
                    end
                end
                FIXUP: begin
                    // strobes are ignored while busy
                    if (dir_fwd) begin
                        pc[15:8] <= pc[15:8] + 8'd1;
                    end else begin
                        pc[15:8] <= pc[15:8] - 8'd1;
                    end
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

    logic        clk_2;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        lower_byte;
    logic        branch;
    logic        branch_rel;
    logic        pc_increment;
    logic        normal;
    logic        pc_hold;
    logic [15:0] pc;
    logic        busy;
    logic        page_cross;

    program_counter dut (
        .clk_2        (clk_2),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .lower_byte   (lower_byte),
        .branch       (branch),
        .branch_rel   (branch_rel),
        .pc_increment (pc_increment),
        .normal       (normal),
        .pc_hold      (pc_hold),
        .pc           (pc),
        .busy         (busy),
        .page_cross   (page_cross)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic [15:0] pc;
        logic        busy;
        logic        pcx;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // One cycle of stimulus: inputs are applied at the falling edge and the
    // state expected after the following rising edge is queued.
    task automatic step(input logic rst, input logic lb, input logic br,
                        input logic rel, input logic inc, input logic nrm,
                        input logic hold, input logic [7:0] d,
                        input logic [15:0] e_pc, input logic e_busy,
                        input logic e_pcx, input string name);
        exp_t e;
        @(negedge clk_2);
        rst_n        = rst;
        lower_byte   = lb;
        branch       = br;
        branch_rel   = rel;
        pc_increment = inc;
        normal       = nrm;
        pc_hold      = hold;
        data_in      = d;
        e.pc   = e_pc;
        e.busy = e_busy;
        e.pcx  = e_pcx;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Absolute load through adl: low byte first, then high byte with branch.
    task automatic load(input logic [15:0] cur, input logic [15:0] target,
                        input string name);
        step(1, 1, 0, 0, 0, 1, 0, target[7:0],  cur,    0, 0, {name, "_lo"});
        step(1, 0, 1, 0, 0, 1, 0, target[15:8], target, 0, 0, {name, "_hi"});
    endtask

    // Monitor: every rising edge the DUT presents a new registered state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_2);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (pc !== e.pc) begin
                    bad++;
                    $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc);
                end
                total++;
                if (busy !== e.busy) begin
                    bad++;
                    $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
                end
                total++;
                if (page_cross !== e.pcx) begin
                    bad++;
                    $display("FAIL %s page_cross: got %b want %b", e.name, page_cross, e.pcx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; data_in = 0; lower_byte = 0; branch = 0; branch_rel = 0;
        pc_increment = 0; normal = 0; pc_hold = 0;

        // reset and reset-vector sequence (branch_rel forced absolute)
        step(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'hFFFC, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'hFFFC, 0, 0, "release");
        step(1, 1, 0, 0, 1, 0, 0, 8'h34, 16'hFFFD, 0, 0, "vec_step1");
        step(1, 0, 1, 1, 0, 0, 0, 8'h12, 16'h1234, 0, 0, "vec_step2");

        // increment wrap
        load(16'h1234, 16'hFFFE, "ld_fffe");
        step(1, 0, 0, 0, 1, 1, 0, 8'h00, 16'hFFFF, 0, 0, "inc_ffff");
        step(1, 0, 0, 0, 1, 1, 0, 8'h00, 16'h0000, 0, 0, "inc_wrap");

        // absolute jump, adl retained
        load(16'h0000, 16'h0200, "ld_0200");
        step(1, 1, 0, 0, 0, 1, 0, 8'hCD, 16'h0200, 0, 0, "abs_lo");
        step(1, 0, 1, 0, 0, 1, 0, 8'hAB, 16'hABCD, 0, 0, "abs_hi");
        step(1, 0, 1, 0, 0, 1, 0, 8'hEF, 16'hEFCD, 0, 0, "adl_kept");

        // forward page crossing; strobes ignored during FIXUP
        load(16'hEFCD, 16'h10F0, "ld_10f0");
        step(1, 0, 1, 1, 0, 1, 0, 8'h20, 16'h1010, 1, 1, "fwd_cross");
        step(1, 1, 1, 0, 1, 1, 0, 8'h55, 16'h1110, 0, 0, "fwd_fixup");
        step(1, 0, 1, 0, 0, 1, 0, 8'h77, 16'h77F0, 0, 0, "lb_ignored");

        // backward page crossing
        load(16'h77F0, 16'h1005, "ld_1005");
        step(1, 0, 1, 1, 0, 1, 0, 8'hF0, 16'h10F5, 1, 1, "bwd_cross");
        step(1, 0, 0, 0, 0, 1, 0, 8'h00, 16'h0FF5, 0, 0, "bwd_fixup");

        // no crossing, simultaneous increment dropped; backward no crossing
        load(16'h0FF5, 16'h3010, "ld_3010");
        step(1, 0, 1, 1, 1, 1, 0, 8'h05, 16'h3015, 0, 0, "rel_noinc");
        step(1, 0, 1, 1, 0, 1, 0, 8'hFB, 16'h3010, 0, 0, "rel_back");

        // FIXUP stalled by pc_hold for two cycles
        load(16'h3010, 16'h20F0, "ld_20f0");
        step(1, 0, 1, 1, 0, 1, 0, 8'h20, 16'h2010, 1, 1, "hold_enter");
        step(1, 0, 0, 0, 0, 1, 1, 8'h00, 16'h2010, 1, 0, "hold_1");
        step(1, 0, 0, 0, 0, 1, 1, 8'h00, 16'h2010, 1, 0, "hold_2");
        step(1, 0, 0, 0, 0, 1, 0, 8'h00, 16'h2110, 0, 0, "hold_done");

        // reset while in FIXUP
        step(1, 0, 1, 1, 0, 1, 0, 8'h80, 16'h2190, 1, 1, "cross_80");
        step(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'hFFFC, 0, 0, "rst_fixup");
        step(1, 0, 0, 0, 0, 1, 0, 8'h00, 16'hFFFC, 0, 0, "post_rst");
        step(1, 0, 0, 0, 1, 1, 0, 8'h00, 16'hFFFD, 0, 0, "post_inc");
        step(1, 0, 0, 0, 1, 1, 1, 8'h00, 16'hFFFD, 0, 0, "hold_inc");
        step(1, 0, 0, 0, 0, 1, 0, 8'h00, 16'hFFFD, 0, 0, "idle");

        repeat (3) @(negedge clk_2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
